mema_row_loader: RTL

//   Upstream feeder for the A-matrix skew FIFO bank (memA). Accepts a narrow valid/ready word

---
 rtl/mema_pkg.sv | 21 ++
 rtl/mema_row_pack.sv | 36 +++
 rtl/mema_row_loader.sv | 118 +++++++++++
 3 files changed

// File: rtl/mema_pkg.sv
// Shared definitions for the memA row loader and memA-side logic.
package mema_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DRAIN = 2'd3
  } mema_state_t;

  // Elements carried by one input word.
  function automatic int mema_epw(input int in_w, input int bits_ab);
    return in_w / bits_ab;
  endfunction

  // Input words needed to assemble one full row.
  function automatic int mema_wpr(input int dim, input int bits_ab, input int in_w);
    return (dim * bits_ab) / in_w;
  endfunction

endpackage

// File: rtl/mema_row_pack.sv
// Word counter and row buffer: packs WPR input words into one row, word 0 in the low bits.
module mema_row_pack #(
  parameter int IN_W = 32,
  parameter int WPR  = 2
) (
  input  logic                      clk,
  input  logic [IN_W-1:0]           in_data,
  input  logic                      accept,
  input  logic                      clear,
  output logic [WPR-1:0][IN_W-1:0]  row,
  output logic                      row_full
);
  localparam int WC_W = (WPR > 1) ? $clog2(WPR) : 1;

  logic [WC_W-1:0]           wcnt;
  logic [WPR-1:0][IN_W-1:0]  buf_q;

  // row includes the word being accepted this cycle so the top can register it directly.
  always_comb begin
    row = buf_q;
    if (accept) row[wcnt] = in_data;
  end

  assign row_full = accept && (wcnt == WC_W'(WPR-1));

  always_ff @(posedge clk) begin
    if (clear) begin
      wcnt  <= '0;
      buf_q <= '0;
    end else if (accept) begin
      buf_q <= row;
      wcnt  <= row_full ? '0 : wcnt + WC_W'(1);
    end
  end

endmodule

// File: rtl/mema_row_loader.sv
// Packs a word stream into DIM-element rows, writes them into memA, then drains the bank.
// Optional MEMA_LOADER_PERF_EN adds the stall_cnt counter/port.
module mema_row_loader
  import mema_pkg::*;
#(
  parameter int BITS_AB   = 8,
  parameter int DIM       = 8,
  parameter int IN_W      = 32,
  parameter int DRAIN_LEN = 3*DIM-1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [IN_W-1:0]                  in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [DIM-1:0][BITS_AB-1:0]      Ain,
  output logic [$clog2(DIM)-1:0]           Arow,
  output logic                             WrEn,
  output logic                             en,
  output logic                             busy,
  output logic                             done
`ifdef MEMA_LOADER_PERF_EN
  ,
  output logic [15:0]                      stall_cnt
`endif
);
  localparam int WPR  = mema_wpr(DIM, BITS_AB, IN_W);
  localparam int RW   = $clog2(DIM);
  localparam int DC_W = $clog2(DRAIN_LEN+1);

  mema_state_t              state;
  logic [RW-1:0]            row_cnt;
  logic [DC_W-1:0]          drain_cnt;
  logic [WPR-1:0][IN_W-1:0] row;
  logic                     row_full;
  logic                     accept;
  logic                     start_idle;

  assign accept     = in_valid && in_ready;
  assign start_idle = (state == IDLE) && start;

  // A fresh start also flushes any partial row left behind.
  mema_row_pack #(.IN_W(IN_W), .WPR(WPR)) u_pack (
    .clk      (clk),
    .in_data  (in_data),
    .accept   (accept),
    .clear    (rst || start_idle),
    .row      (row),
    .row_full (row_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      row_cnt   <= '0;
      drain_cnt <= '0;
      Ain       <= '0;
      Arow      <= '0;
      WrEn      <= 1'b0;
      en        <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      WrEn <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state    <= LOAD;
          in_ready <= 1'b1;
          busy     <= 1'b1;
          row_cnt  <= '0;
        end
        LOAD: if (row_full) begin
          state    <= WRITE;
          in_ready <= 1'b0;
          WrEn     <= 1'b1;
          Ain      <= row;
          Arow     <= row_cnt;
        end
        WRITE: begin
          if (row_cnt == RW'(DIM-1)) begin
            row_cnt   <= '0;
            state     <= DRAIN;
            en        <= 1'b1;
            drain_cnt <= '0;
          end else begin
            row_cnt  <= row_cnt + RW'(1);
            state    <= LOAD;
            in_ready <= 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == DC_W'(DRAIN_LEN-1)) begin
            state <= IDLE;
            en    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DC_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEMA_LOADER_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || start_idle)
      stall_cnt <= '0;
    else if (state == LOAD && !in_valid && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule
